ray_dispatcher: RTL and testbench



---
 rtl/ray_pkg.sv | 13 +
 rtl/ray_dispatch_arb.sv | 17 +
 rtl/ray_dispatcher.sv | 101 ++++++++++
 tb/tb_ray_dispatcher.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_pkg.sv
// Shared types and defaults for the frame-level ray dispatcher.
package ray_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } dispatch_state_t;

    localparam int SCREEN_W_DEFAULT = 640;

endpackage

// File: rtl/ray_dispatch_arb.sv
// Combinational lowest-index-first picker over the free ray units.
module ray_dispatch_arb #(
    parameter int NUM_UNITS = 2
) (
    input  logic [NUM_UNITS-1:0] busy_i,
    output logic [NUM_UNITS-1:0] grant_o,
    output logic                 found_o
);

    logic [NUM_UNITS-1:0] free;

    // Two's-complement trick isolates the lowest set bit of the free mask.
    assign free    = ~busy_i;
    assign grant_o = free & (~free + NUM_UNITS'(1));
    assign found_o = |free;

endmodule

// File: rtl/ray_dispatcher.sv
// Frame-level ray scheduler: issues column indices to free ray units and
// reports frame completion once every issued ray has retired.
module ray_dispatcher
    import ray_pkg::*;
#(
    parameter int NUM_UNITS = 2,
    parameter int SCREEN_W  = SCREEN_W_DEFAULT,
    parameter int IDX_W     = $clog2(SCREEN_W)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 continuous,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic [NUM_UNITS-1:0] issue_valid,
    output logic [IDX_W-1:0]     issue_index,
    output logic [NUM_UNITS-1:0] unit_busy,
    output logic                 busy,
    output logic                 frame_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SCREEN_W - 1);

    dispatch_state_t      state_q, state_d;
    logic [IDX_W-1:0]     next_index_q, next_index_d;
    logic [NUM_UNITS-1:0] unit_busy_q, unit_busy_d;
    logic [NUM_UNITS-1:0] issue_valid_q, issue_valid_d;
    logic [IDX_W-1:0]     issue_index_q, issue_index_d;
    logic                 busy_q, frame_done_q;
    logic [NUM_UNITS-1:0] grant;
    logic                 found;

    // Selection looks only at pre-edge busy, so a unit retiring this cycle
    // cannot be re-issued until the following cycle.
    ray_dispatch_arb #(.NUM_UNITS(NUM_UNITS)) u_arb (
        .busy_i  (unit_busy_q),
        .grant_o (grant),
        .found_o (found)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d       = state_q;
        next_index_d  = next_index_q;
        issue_valid_d = '0;
        issue_index_d = issue_index_q;
        unit_busy_d   = unit_busy_q & ~unit_done;

        case (state_q)
            IDLE: begin
                next_index_d = '0;
                if (frame_start) state_d = ISSUE;
            end
            ISSUE: begin
                if (found) begin
                    issue_valid_d = grant;
                    issue_index_d = next_index_q;
                    unit_busy_d   = unit_busy_d | grant;
                    if (next_index_q == LAST_IDX) state_d = DRAIN;
                    else next_index_d = next_index_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                if (unit_busy_q == '0) state_d = DONE;
            end
            DONE: begin
                next_index_d = '0;
                state_d      = continuous ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            next_index_q  <= '0;
            unit_busy_q   <= '0;
            issue_valid_q <= '0;
            issue_index_q <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            next_index_q  <= next_index_d;
            unit_busy_q   <= unit_busy_d;
            issue_valid_q <= issue_valid_d;
            issue_index_q <= issue_index_d;
            busy_q        <= (state_d != IDLE);
            frame_done_q  <= (state_d == DONE);
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_index = issue_index_q;
    assign unit_busy   = unit_busy_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ray_dispatcher.sv
// Scoreboard bench for ray_dispatcher with 2 units and an 8-ray frame.
module tb_ray_dispatcher;

    localparam int NU = 2;
    localparam int SW = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset, frame_start, continuous;
    logic [NU-1:0] unit_done, issue_valid, unit_busy;
    logic [IW-1:0] issue_index;
    logic          busy, frame_done;

    logic [NU-1:0] auto_done, man_done, hold;
    logic          auto_en;

    assign unit_done = auto_done | man_done;

    ray_dispatcher #(.NUM_UNITS(NU), .SCREEN_W(SW), .IDX_W(IW)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .continuous  (continuous),
        .unit_done   (unit_done),
        .issue_valid (issue_valid),
        .issue_index (issue_index),
        .unit_busy   (unit_busy),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NU-1:0] unit;
        logic [IW-1:0] idx;
    } issue_t;

    issue_t exp_q[$];
    issue_t exp_e;
    int     n_cmp = 0, n_err = 0;
    int     n_issue = 0, fd_cnt = 0, cyc = 0, fd_cyc = 0, idx0_gap = 0;
    int     issue_cyc[SW];
    logic   prev_fd = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Ray units retire one cycle after issue unless held.
    always @(posedge clk) begin
        #1;
        auto_done = auto_en ? (issue_valid & ~hold) : '0;
    end

    // Monitor: pops the scoreboard whenever the DUT issues a ray.
    always @(negedge clk) begin
        if (!reset) begin
            if (issue_valid != '0) begin
                n_issue++;
                issue_cyc[issue_index] = cyc;
                if (issue_index == '0) idx0_gap = cyc - fd_cyc;
                if (exp_q.size() == 0) begin
                    check("issue_unexpected", 32'(issue_valid), 32'd0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("issue_unit", 32'(issue_valid), 32'(exp_e.unit));
                    check("issue_index", 32'(issue_index), 32'(exp_e.idx));
                end
            end
            if (frame_done) begin
                check("frame_done_pulse", 32'(prev_fd), 32'd0);
                fd_cnt++;
                fd_cyc = cyc;
            end
        end
        prev_fd = frame_done;
    end

    // Retire pulses aimed at idle units are a stimulus error.
    always @(negedge clk) begin
        #2;
        if (!reset && ((unit_done & ~unit_busy) != '0))
            check("done_on_idle_unit", 32'(unit_done & ~unit_busy), 32'd0);
    end

    task automatic push(input int unit, input int idx);
        exp_q.push_back(issue_t'{unit: NU'(1 << unit), idx: IW'(idx)});
    endtask

    task automatic push_frame();
        for (int i = 0; i < SW; i++) push(i % 2, i);
    endtask

    task automatic pulse_start();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
    endtask

    task automatic man_pulse(input logic [NU-1:0] v);
        @(negedge clk); #1 man_done = v;
        @(negedge clk); #1 man_done = '0;
    endtask

    task automatic wait_fd(input int target, input int budget);
        int n = 0;
        while (fd_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_count", 32'(fd_cnt), 32'(target));
    endtask

    task automatic release_units();
        @(negedge clk); #1 hold = '0; man_done = '1;
        @(negedge clk); #1 man_done = '0;
    endtask

    // Full frame with a frame_start re-pulse mid-ISSUE; the last two rays are
    // held so the frame parks in DRAIN with both units busy.
    task automatic run_to_drain();
        hold = '0;
        push_frame();
        pulse_start();
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            if (t == 2) frame_start = 1'b1;
            if (t == 3) frame_start = 1'b0;
            if (t == 6) hold = '1;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base, nf, n, c;
        reset = 1'b1; frame_start = 1'b0; continuous = 1'b0;
        man_done = '0; auto_done = '0; hold = '0; auto_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_issue_valid", 32'(issue_valid), 32'd0);
        check("rst_issue_index", 32'(issue_index), 32'd0);
        check("rst_unit_busy", 32'(unit_busy), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        reset = 1'b0;

        // Back-to-back frame, units alternate with no gaps.
        push_frame();
        pulse_start();
        wait_fd(1, 40);
        check("t1_no_gaps", 32'(issue_cyc[7] - issue_cyc[0]), 32'd7);
        repeat (2) @(negedge clk);
        check("t1_busy_idle", 32'(busy), 32'd0);
        check("t1_units_idle", 32'(unit_busy), 32'd0);

        // Units never retire: stall after two issues, then unit1 frees.
        hold = '1;
        base = n_issue;
        push(0, 0); push(1, 1); push(1, 2);
        push(0, 3); push(1, 4); push(0, 5); push(1, 6); push(0, 7);
        pulse_start();
        repeat (6) @(negedge clk);
        check("t2_stall_count", 32'(n_issue - base), 32'd2);
        check("t2_stall_busy", 32'(unit_busy), 32'h3);
        man_pulse(2'b10);
        repeat (3) @(negedge clk);
        check("t2_after_retire", 32'(n_issue - base), 32'd3);
        release_units();
        wait_fd(2, 40);

        // frame_start ignored during ISSUE and DRAIN.
        run_to_drain();
        check("t3_drain_busy", 32'(unit_busy), 32'h3);
        base = n_issue;
        pulse_start();
        repeat (2) @(negedge clk);
        check("t3_drain_no_issue", 32'(n_issue - base), 32'd0);
        check("t3_drain_state", 32'(busy), 32'd1);
        check("t3_no_early_done", 32'(fd_cnt), 32'd2);
        man_pulse(2'b11);
        wait_fd(3, 20);
        repeat (2) @(negedge clk);
        check("t3_busy_idle", 32'(busy), 32'd0);

        // Asynchronous reset in DRAIN abandons the frame.
        run_to_drain();
        check("t4_drain_busy", 32'(unit_busy), 32'h3);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t4_rst_issue_index", 32'(issue_index), 32'd0);
        check("t4_rst_unit_busy", 32'(unit_busy), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk) reset = 1'b0;
        hold = '0;
        repeat (3) @(negedge clk);
        check("t4_no_frame_done", 32'(fd_cnt), 32'd3);
        push_frame();
        pulse_start();
        wait_fd(4, 40);

        // Retire of unit0 while both busy: unit0 re-issued one cycle later.
        hold = '1;
        base = n_issue;
        push(0, 0); push(1, 1); push(0, 2);
        push(0, 3); push(1, 4); push(0, 5); push(1, 6); push(0, 7);
        pulse_start();
        repeat (5) @(negedge clk);
        @(negedge clk); #1 man_done = 2'b01; c = cyc;
        @(negedge clk); #1 man_done = '0;
        repeat (3) @(negedge clk);
        check("t5_reissue_count", 32'(n_issue - base), 32'd3);
        check("t5_reissue_delay", 32'(issue_cyc[2] - c), 32'd2);
        release_units();
        wait_fd(5, 40);

        // Continuous mode: three frames, then drop back to IDLE.
        continuous = 1'b1;
        repeat (3) push_frame();
        pulse_start();
        nf = 0;
        n  = 0;
        while (nf < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (frame_done) begin
                nf++;
                if (nf == 3) continuous = 1'b0;
            end
        end
        check("t6_frames", 32'(nf), 32'd3);
        check("t6_restart_gap", 32'(idx0_gap), 32'd2);
        repeat (4) @(negedge clk);
        check("t6_busy_idle", 32'(busy), 32'd0);
        check("t6_total_done", 32'(fd_cnt), 32'd8);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
